// File: rtl/idli_pkg.sv
// Shared types for the idli core: SIO nibble, SQI command codes and SQI RAM states.
package idli_pkg;

  // One 4-bit SIO transfer.
  typedef logic [3:0] slice_t;

  // Field lengths, in nibbles, of the SQI transaction header.
  localparam int unsigned SQI_CMD_NIBBLES  = 2;
  localparam int unsigned SQI_ADDR_NIBBLES = 4;

  // Commands understood by the SQI RAM.
  typedef enum logic [7:0] {
    SQI_CMD_WRITE = 8'h02,
    SQI_CMD_READ  = 8'h03
  } sqi_cmd_t;

  // Transaction phases of the SQI RAM.
  typedef enum logic [2:0] {
    CMD,
    ADDR,
    DUMMY,
    READ,
    WRITE,
    IGNORE
  } sqi_state_t;

endpackage

// File: rtl/idli_sqi_ram_m_if.sv
// Host-side SQI bus bundle: chip select plus nibble-wide SIO in each direction.
interface idli_sqi_ram_m_if;
  import idli_pkg::*;

  logic   cs;
  slice_t sio_in;
  slice_t sio_out;

  modport master (output cs, output sio_in, input  sio_out);
  modport slave  (input  cs, input  sio_in, output sio_out);

endinterface

// File: rtl/idli_sqi_ram_m.sv
// Behavioural SQI serial SRAM: nibble-wide READ/WRITE transactions into a flat byte array.
module idli_sqi_ram_m
  import idli_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DUMMY_N = 2
) (
  input  logic   i_sqi_sck,
  input  logic   i_sqi_rst,
  input  logic   i_sqi_cs,
  input  slice_t i_sqi_sio,
  output slice_t o_sqi_sio
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = 3;

  // Storage; name is fixed so benches can preload it hierarchically.
  logic [7:0] data_q [DEPTH];

  sqi_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic               phase_q, phase_d;   // 0 = high nibble, 1 = low nibble
  slice_t             nib_q,   nib_d;     // first cmd nibble / pending write high nibble
  logic               rd_q,    rd_d;      // header belongs to a READ
  slice_t             sio_q;
  logic               we_c;
  logic [7:0]         rd_byte_c;

  // Next-state decode on each rising sck; deselect overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    nib_d   = nib_q;
    rd_d    = rd_q;
    we_c    = 1'b0;
    if (i_sqi_cs) begin
      state_d = CMD;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        CMD: begin
          if (cnt_q == CNT_W'(0)) begin
            nib_d = i_sqi_sio;
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d = '0;
            case ({nib_q, i_sqi_sio})
              SQI_CMD_READ:  begin rd_d = 1'b1; state_d = ADDR; end
              SQI_CMD_WRITE: begin rd_d = 1'b0; state_d = ADDR; end
              default:       state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          addr_d = {addr_q[ADDR_W-5:0], i_sqi_sio};
          if (cnt_q == CNT_W'(SQI_ADDR_NIBBLES - 1)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            if (!rd_q)             state_d = WRITE;
            else if (DUMMY_N == 0) state_d = READ;
            else                   state_d = DUMMY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DUMMY: begin
          if (cnt_q == CNT_W'(DUMMY_N - 1)) begin
            cnt_d   = '0;
            state_d = READ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        READ: begin
          phase_d = ~phase_q;
          if (phase_q) addr_d = addr_q + ADDR_W'(1);
        end
        WRITE: begin
          if (!phase_q) begin
            nib_d   = i_sqi_sio;
            phase_d = 1'b1;
          end else begin
            we_c    = 1'b1;
            addr_d  = addr_q + ADDR_W'(1);
            phase_d = 1'b0;
          end
        end
        IGNORE:  state_d = IGNORE;
        default: state_d = CMD;
      endcase
    end
  end

  // Control state register; reset aborts any transaction in flight.
  always_ff @(posedge i_sqi_sck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state_q <= CMD;
      cnt_q   <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      nib_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      nib_q   <= nib_d;
      rd_q    <= rd_d;
    end
  end

  // Byte commit on the edge that captures its low nibble; contents survive reset.
  always_ff @(posedge i_sqi_sck) begin
    if (we_c) data_q[addr_q] <= {nib_q, i_sqi_sio};
  end

  assign rd_byte_c = data_q[addr_q];

  // Read data launched on falling sck so the host can capture it on the next rise.
  always_ff @(negedge i_sqi_sck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      sio_q <= '0;
    end else if (state_q == READ && !i_sqi_cs) begin
      sio_q <= phase_q ? rd_byte_c[3:0] : rd_byte_c[7:4];
    end else begin
      sio_q <= '0;
    end
  end

  // Bus is quiet as soon as the chip is deselected.
  assign o_sqi_sio = i_sqi_cs ? slice_t'(0) : sio_q;

endmodule

// File: tb/tb_idli_sqi_ram_m.sv
// Directed plus randomized bench for idli_sqi_ram_m against a byte-array reference model.
module tb_idli_sqi_ram_m;
  import idli_pkg::*;

  localparam int unsigned DUMMY_N = 2;

  logic sck;
  logic rst;
  idli_sqi_ram_m_if bus ();

  idli_sqi_ram_m #(.ADDR_W(16), .DUMMY_N(DUMMY_N)) dut (
    .i_sqi_sck (sck),
    .i_sqi_rst (rst),
    .i_sqi_cs  (bus.cs),
    .i_sqi_sio (bus.sio_in),
    .o_sqi_sio (bus.sio_out)
  );

  // Reference memory: only addresses the bench has written are tracked.
  logic [7:0] mem [int];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full sck period presenting v on the rising edge; ends just after the falling edge.
  task automatic tick(input slice_t v);
    bus.sio_in = v;
    #5 sck = 1'b1;
    #5 sck = 1'b0;
    #2;
  endtask

  // Nibble sent while the output must stay quiet.
  task automatic tick_quiet(input string tag, input slice_t v);
    tick(v);
    check(tag, 8'(bus.sio_out), 8'h00);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [15:0] a);
    tick_quiet("cmd_zero", cmd[7:4]);
    tick_quiet("cmd_zero", cmd[3:0]);
    tick_quiet("addr_zero", a[15:12]);
    tick_quiet("addr_zero", a[11:8]);
    tick_quiet("addr_zero", a[7:4]);
    tick_quiet("addr_zero", a[3:0]);
  endtask

  task automatic deselect();
    bus.cs = 1'b1;
    #1 check("desel_zero", 8'(bus.sio_out), 8'h00);
    tick(slice_t'($urandom));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] data[$], input bit partial);
    logic [15:0] p = a;
    bus.cs = 1'b0;
    send_header(8'h02, a);
    foreach (data[i]) begin
      tick_quiet("wr_zero", data[i][7:4]);
      tick_quiet("wr_zero", data[i][3:0]);
      mem[int'(p)] = data[i];
      p = p + 16'd1;
    end
    if (partial) tick_quiet("wr_zero", slice_t'($urandom));
    deselect();
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic [15:0] p = a;
    logic [7:0]  e;
    bus.cs = 1'b0;
    send_header(8'h03, a);
    for (int i = 0; i < int'(DUMMY_N) - 1; i++) tick_quiet("dummy_zero", slice_t'($urandom));
    tick(slice_t'($urandom));
    for (int b = 0; b < n; b++) begin
      e = mem.exists(int'(p)) ? mem[int'(p)] : 8'hxx;
      check("rd_hi", 8'(bus.sio_out), 8'(e[7:4]));
      tick(slice_t'($urandom));
      check("rd_lo", 8'(bus.sio_out), 8'(e[3:0]));
      tick(slice_t'($urandom));
      p = p + 16'd1;
    end
    deselect();
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [15:0] ra[$];
    int          rn[$];
    logic [15:0] a;
    int          n;

    sck = 1'b0;
    rst = 1'b1;
    bus.cs = 1'b0;
    bus.sio_in = '0;
    #10;
    check("reset_out", 8'(bus.sio_out), 8'h00);
    bus.cs = 1'b1;
    tick(4'h0);
    rst = 1'b0;
    tick(4'h0);

    // Preload and read across a byte boundary.
    q = '{8'hA5, 8'h3C};
    do_write(16'h0010, q, 1'b0);
    do_read(16'h0010, 2);

    // Write then read in a new transaction.
    q = '{8'hDE, 8'hAD};
    do_write(16'h1234, q, 1'b0);
    do_read(16'h1234, 2);

    // Address wrap at the top of memory.
    q = '{8'h11, 8'h22};
    do_write(16'hFFFF, q, 1'b0);
    do_read(16'hFFFF, 2);
    check("wrap_ffff", dut.data_q[16'hFFFF], 8'h11);
    check("wrap_0000", dut.data_q[16'h0000], 8'h22);

    // Half a byte followed by deselect leaves memory alone.
    q = '{8'h5A};
    do_write(16'h0020, q, 1'b0);
    bus.cs = 1'b0;
    send_header(8'h02, 16'h0020);
    tick_quiet("wr_zero", 4'h7);
    deselect();
    do_read(16'h0020, 1);

    // Unknown command: bus stays quiet.
    bus.cs = 1'b0;
    tick_quiet("ign_zero", 4'hF);
    tick_quiet("ign_zero", 4'hF);
    for (int i = 0; i < 10; i++) tick_quiet("ign_zero", slice_t'($urandom));
    deselect();

    // Reset mid-read with sck idle silences the bus at once.
    bus.cs = 1'b0;
    send_header(8'h03, 16'h0010);
    for (int i = 0; i < int'(DUMMY_N); i++) tick(4'h0);
    check("pre_rst_hi", 8'(bus.sio_out), 8'h0A);
    rst = 1'b1;
    #1 check("rst_mid_read", 8'(bus.sio_out), 8'h00);
    bus.cs = 1'b1;
    #3 rst = 1'b0;
    tick(4'h0);
    do_read(16'h0010, 2);

    // Reset between the two nibbles of a write byte drops it.
    q = '{8'h66};
    do_write(16'h0030, q, 1'b0);
    bus.cs = 1'b0;
    send_header(8'h02, 16'h0030);
    tick(4'h9);
    rst = 1'b1;
    tick(4'h1);
    bus.cs = 1'b1;
    tick(4'h0);
    rst = 1'b0;
    tick(4'h0);
    do_read(16'h0030, 1);

    // Randomized bursts, read back after all writes land.
    for (int t = 0; t < 8; t++) begin
      a = (t == 0) ? 16'hFFFE : 16'($urandom);
      n = int'($urandom_range(1, 4));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      do_write(a, q, 1'($urandom));
      ra.push_back(a);
      rn.push_back(n);
    end
    foreach (ra[i]) do_read(ra[i], rn[i]);

    // Whole-array comparison of every tracked byte.
    foreach (mem[k]) check("mem_final", dut.data_q[16'(k)], mem[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
